ulpb_rx_ahb_master: RTL and testbench

ULPB_RX_AHB_MASTER -- requirements
Module: ulpb_rx_ahb_master

---
 rtl/ulpb_rx_ahb_master.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ulpb_rx_ahb_master.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpb_rx_ahb_master.sv
// ulpb_rx_ahb_master
//   Receives messages from a ULPB node over a four-phase REQ/ACK handshake
//   and writes them as single 32-bit AHB-Lite transfers into a word ring
//   in system memory. Software consumes the ring through RD_PTR. The block
//   exposes the producer index on WR_PTR.
//
// Ports
//   HCLK, RESET          clock; synchronous active-high reset
//   ADDR_OUT, DATA_OUT   node message (stable while REQ_OUT_TO_LC is high)
//   REQ_OUT_TO_LC        node request (SCLK domain, synchronised here)
//   ACK_IN_FROM_LC       registered four-phase acknowledge back to the node
//   H*                   AHB-Lite master: single NONSEQ word writes
//   RD_PTR / WR_PTR      consumer / producer word indices into the ring
//   ERR_CLR / ERR        sticky bus-error flag and its clear
//   RX_IRQ               one-cycle pulse per successfully stored message
//
// Configuration
//   ULPB_RX_HDR_EN  defined: each message is two words, the header
//                   {24'h0, ADDR_OUT} followed by DATA_OUT.
//                   undefined: each message is DATA_OUT only.
module ulpb_rx_ahb_master #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                     HCLK,
  input  logic                     RESET,
  input  logic [7:0]               ADDR_OUT,
  input  logic [31:0]              DATA_OUT,
  input  logic                     REQ_OUT_TO_LC,
  output logic                     ACK_IN_FROM_LC,
  output logic [31:0]              HADDR,
  output logic [1:0]               HTRANS,
  output logic                     HWRITE,
  output logic [2:0]               HSIZE,
  output logic [2:0]               HBURST,
  output logic [3:0]               HPROT,
  output logic                     HMASTLOCK,
  output logic [31:0]              HWDATA,
  input  logic                     HREADY,
  input  logic                     HRESP,
  input  logic [$clog2(DEPTH)-1:0] RD_PTR,
  output logic [$clog2(DEPTH)-1:0] WR_PTR,
  input  logic                     ERR_CLR,
  output logic                     ERR,
  output logic                     RX_IRQ
);

  localparam int unsigned PW = $clog2(DEPTH);

`ifdef ULPB_RX_HDR_EN
  localparam int unsigned WPM = 2;
`else
  localparam int unsigned WPM = 1;
`endif

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPT,
    ST_ADDR,
    ST_DATA,
    ST_ACK,
    ST_WAITLO
  } state_t;

  state_t          state_q, state_d;
  logic            req_meta_q, req_meta_d;
  logic            req_s_q, req_s_d;
  logic            ack_q, ack_d;
  logic [1:0]      htrans_q, htrans_d;
  logic [31:0]     haddr_q, haddr_d;
  logic [31:0]     hwdata_q, hwdata_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   wr_ptr_save_q, wr_ptr_save_d;
  logic            err_q, err_d;
  logic            rx_irq_q, rx_irq_d;
  logic            msg_err_q, msg_err_d;
  logic            word_idx_q, word_idx_d;
  logic [31:0]     cap_data_q, cap_data_d;

  logic [PW-1:0]   used_slots;
  logic [PW:0]     free_slots;
  logic [PW-1:0]   wr_ptr_inc;
  logic            last_word;
  logic            err_set;
  logic [31:0]     cur_word;

`ifdef ULPB_RX_HDR_EN
  logic [7:0]      cap_addr_q, cap_addr_d;

  assign cur_word = (word_idx_q == 1'b0) ? {24'h0, cap_addr_q} : cap_data_q;
`else
  logic            addr_unused;

  assign addr_unused = ^ADDR_OUT;
  assign cur_word    = cap_data_q;
`endif

  // Ring occupancy; the PW-bit subtraction wraps modulo DEPTH by itself.
  assign used_slots = wr_ptr_q - RD_PTR;
  assign free_slots = (PW+1)'(DEPTH - 1) - {1'b0, used_slots};
  assign wr_ptr_inc = wr_ptr_q + PW'(1);
  assign last_word  = (word_idx_q == 1'(WPM - 1));

  always_comb begin
    state_d       = state_q;
    req_meta_d    = REQ_OUT_TO_LC;
    req_s_d       = req_meta_q;
    ack_d         = ack_q;
    htrans_d      = htrans_q;
    haddr_d       = haddr_q;
    hwdata_d      = hwdata_q;
    wr_ptr_d      = wr_ptr_q;
    wr_ptr_save_d = wr_ptr_save_q;
    rx_irq_d      = 1'b0;
    msg_err_d     = msg_err_q;
    word_idx_d    = word_idx_q;
    cap_data_d    = cap_data_q;
`ifdef ULPB_RX_HDR_EN
    cap_addr_d    = cap_addr_q;
`endif
    err_set       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // RD_PTR is only consulted here, so later software updates cannot
        // disturb a message already in flight.
        if (req_s_q && !ack_q && (free_slots >= (PW+1)'(WPM))) begin
          state_d = ST_CAPT;
        end
      end

      ST_CAPT: begin
        cap_data_d    = DATA_OUT;
`ifdef ULPB_RX_HDR_EN
        cap_addr_d    = ADDR_OUT;
`endif
        wr_ptr_save_d = wr_ptr_q;
        word_idx_d    = 1'b0;
        msg_err_d     = 1'b0;
        htrans_d      = HTRANS_NONSEQ;
        haddr_d       = BASE_ADDR + 32'({wr_ptr_q, 2'b00});
        state_d       = ST_ADDR;
      end

      ST_ADDR: begin
        if (HREADY) begin
          htrans_d = HTRANS_IDLE;
          hwdata_d = cur_word;
          state_d  = ST_DATA;
        end
      end

      ST_DATA: begin
        // The first cycle of a two-cycle error response already flags the
        // message; completion waits for HREADY as for a normal transfer.
        if (HRESP) begin
          err_set   = 1'b1;
          msg_err_d = 1'b1;
        end
        if (HREADY) begin
          if (HRESP || msg_err_q) begin
            wr_ptr_d = wr_ptr_save_q;
            ack_d    = 1'b1;
            state_d  = ST_ACK;
          end else if (last_word) begin
            wr_ptr_d = wr_ptr_inc;
            ack_d    = 1'b1;
            rx_irq_d = 1'b1;
            state_d  = ST_ACK;
          end else begin
            wr_ptr_d   = wr_ptr_inc;
            word_idx_d = word_idx_q + 1'b1;
            htrans_d   = HTRANS_NONSEQ;
            haddr_d    = BASE_ADDR + 32'({wr_ptr_inc, 2'b00});
            state_d    = ST_ADDR;
          end
        end
      end

      ST_ACK: begin
        state_d = ST_WAITLO;
      end

      ST_WAITLO: begin
        if (!req_s_q) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        ack_d    = 1'b0;
        htrans_d = HTRANS_IDLE;
      end
    endcase

    // A new error in the same cycle as a clear keeps the flag set.
    if (err_set) begin
      err_d = 1'b1;
    end else if (ERR_CLR) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge HCLK) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      req_meta_q    <= 1'b0;
      req_s_q       <= 1'b0;
      ack_q         <= 1'b0;
      htrans_q      <= HTRANS_IDLE;
      haddr_q       <= BASE_ADDR;
      hwdata_q      <= '0;
      wr_ptr_q      <= '0;
      wr_ptr_save_q <= '0;
      err_q         <= 1'b0;
      rx_irq_q      <= 1'b0;
      msg_err_q     <= 1'b0;
      word_idx_q    <= 1'b0;
      cap_data_q    <= '0;
`ifdef ULPB_RX_HDR_EN
      cap_addr_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      req_meta_q    <= req_meta_d;
      req_s_q       <= req_s_d;
      ack_q         <= ack_d;
      htrans_q      <= htrans_d;
      haddr_q       <= haddr_d;
      hwdata_q      <= hwdata_d;
      wr_ptr_q      <= wr_ptr_d;
      wr_ptr_save_q <= wr_ptr_save_d;
      err_q         <= err_d;
      rx_irq_q      <= rx_irq_d;
      msg_err_q     <= msg_err_d;
      word_idx_q    <= word_idx_d;
      cap_data_q    <= cap_data_d;
`ifdef ULPB_RX_HDR_EN
      cap_addr_q    <= cap_addr_d;
`endif
    end
  end

  assign ACK_IN_FROM_LC = ack_q;
  assign HTRANS         = htrans_q;
  assign HADDR          = haddr_q;
  assign HWDATA         = hwdata_q;
  assign WR_PTR         = wr_ptr_q;
  assign ERR            = err_q;
  assign RX_IRQ         = rx_irq_q;

  // Only writes are ever issued, so HWRITE can stay high unconditionally.
  assign HWRITE         = 1'b1;
  assign HSIZE          = 3'b010;
  assign HBURST         = 3'b000;
  assign HPROT          = 4'b0011;
  assign HMASTLOCK      = 1'b0;

endmodule

// File: tb/tb_ulpb_rx_ahb_master.sv
// Bench for ulpb_rx_ahb_master: an AHB-Lite slave with programmable wait
// states and error injection, a bus monitor collecting completed writes,
// and a ring model (expected write pointer, addresses, IRQ count).
module tb_ulpb_rx_ahb_master;

  localparam logic [31:0] BASE        = 32'h2000_0000;
  localparam int unsigned DEPTH       = 16;
  localparam int unsigned PW          = $clog2(DEPTH);
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned TIMEOUT     = 200;
`ifdef ULPB_RX_HDR_EN
  localparam int unsigned WPM = 2;
`else
  localparam int unsigned WPM = 1;
`endif

  logic          HCLK = 1'b0;
  logic          RESET = 1'b1;
  logic [7:0]    ADDR_OUT = '0;
  logic [31:0]   DATA_OUT = '0;
  logic          REQ_OUT_TO_LC = 1'b0;
  logic          ACK_IN_FROM_LC;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [3:0]    HPROT;
  logic          HMASTLOCK;
  logic [31:0]   HWDATA;
  logic          HREADY = 1'b1;
  logic          HRESP = 1'b0;
  logic [PW-1:0] RD_PTR = '0;
  logic [PW-1:0] WR_PTR;
  logic          ERR_CLR = 1'b0;
  logic          ERR;
  logic          RX_IRQ;

  ulpb_rx_ahb_master #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH)
  ) dut (
    .HCLK           (HCLK),
    .RESET          (RESET),
    .ADDR_OUT       (ADDR_OUT),
    .DATA_OUT       (DATA_OUT),
    .REQ_OUT_TO_LC  (REQ_OUT_TO_LC),
    .ACK_IN_FROM_LC (ACK_IN_FROM_LC),
    .HADDR          (HADDR),
    .HTRANS         (HTRANS),
    .HWRITE         (HWRITE),
    .HSIZE          (HSIZE),
    .HBURST         (HBURST),
    .HPROT          (HPROT),
    .HMASTLOCK      (HMASTLOCK),
    .HWDATA         (HWDATA),
    .HREADY         (HREADY),
    .HRESP          (HRESP),
    .RD_PTR         (RD_PTR),
    .WR_PTR         (WR_PTR),
    .ERR_CLR        (ERR_CLR),
    .ERR            (ERR),
    .RX_IRQ         (RX_IRQ)
  );

  initial forever #5 HCLK = ~HCLK;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Ring model and monitor state
  int unsigned exp_wr       = 0;
  int unsigned irq_cnt      = 0;
  int unsigned nonseq_cnt   = 0;
  int unsigned unstable_cnt = 0;
  int unsigned const_bad    = 0;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic        wq_resp[$];
  bit          dphase  = 1'b0;
  logic [31:0] daddr   = '0;
  bit          prev_aw = 1'b0;
  bit          prev_dw = 1'b0;
  logic [31:0] hold_addr = '0;
  logic [31:0] hold_data = '0;

  // Slave configuration
  int unsigned cfg_wait  = 0;
  bit          err_arm   = 1'b0;
  int unsigned lowcnt    = 0;
  bit          err_phase = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: samples at the rising edge (pre-update values).
  initial begin
    forever begin
      @(posedge HCLK);
      if (RESET) begin
        dphase  = 1'b0;
        prev_aw = 1'b0;
        prev_dw = 1'b0;
      end else begin
        if (RX_IRQ) irq_cnt++;
        if (prev_aw && (HADDR !== hold_addr || HTRANS !== 2'b10)) unstable_cnt++;
        if (prev_dw && HWDATA !== hold_data) unstable_cnt++;
        if (HSIZE !== 3'b010 || HBURST !== 3'b000 || HPROT !== 4'b0011 ||
            HMASTLOCK !== 1'b0 || (HTRANS !== 2'b00 && HWRITE !== 1'b1)) const_bad++;
        prev_aw   = (HTRANS == 2'b10) && !HREADY;
        hold_addr = HADDR;
        prev_dw   = dphase && !HREADY;
        hold_data = HWDATA;
        if (dphase && HREADY) begin
          wq_addr.push_back(daddr);
          wq_data.push_back(HWDATA);
          wq_resp.push_back(HRESP);
          dphase = 1'b0;
        end
        if (HTRANS == 2'b10 && HREADY) begin
          dphase = 1'b1;
          daddr  = HADDR;
          nonseq_cnt++;
        end
      end
    end
  end

  // AHB slave: cfg_wait low cycles per phase, two-cycle error response
  // on the first data phase after err_arm is set.
  initial begin
    forever begin
      @(negedge HCLK);
      if (dphase && err_arm) begin
        HRESP = 1'b1;
        if (!err_phase) begin
          HREADY    = 1'b0;
          err_phase = 1'b1;
        end else begin
          HREADY    = 1'b1;
          err_phase = 1'b0;
          err_arm   = 1'b0;
        end
      end else if (HTRANS == 2'b10 || dphase) begin
        HRESP = 1'b0;
        if (lowcnt < cfg_wait) begin
          HREADY = 1'b0;
          lowcnt++;
        end else begin
          HREADY = 1'b1;
          lowcnt = 0;
        end
      end else begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        lowcnt = 0;
      end
    end
  end

  task automatic raise_req(input logic [7:0] a, input logic [31:0] d);
    @(negedge HCLK);
    ADDR_OUT      = a;
    DATA_OUT      = d;
    REQ_OUT_TO_LC = 1'b1;
  endtask

  task automatic wait_ack(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    for (int i = 1; i <= int'(TIMEOUT) && !seen; i++) begin
      @(posedge HCLK); #1;
      if (lat < 0 && HTRANS == 2'b10) lat = i;
      if (ACK_IN_FROM_LC) seen = 1'b1;
    end
    check("ack_rise", 32'(seen), 32'd1);
  endtask

  task automatic drop_req();
    int  n;
    bit  low;
    n   = 0;
    low = 1'b0;
    @(negedge HCLK);
    REQ_OUT_TO_LC = 1'b0;
    for (int i = 1; i <= int'(TIMEOUT) && !low; i++) begin
      @(posedge HCLK); #1;
      n = i;
      if (!ACK_IN_FROM_LC) low = 1'b1;
    end
    check("ack_fall_delay", 32'(n), 32'(SYNC_STAGES + 1));
  endtask

  task automatic expect_msg(input logic [7:0] a, input logic [31:0] d, input bit err,
                            input int unsigned irq0);
    logic [31:0] words [2];
    int unsigned nw;
    words[0] = (WPM == 2) ? {24'h0, a} : d;
    words[1] = d;
    nw = err ? 1 : WPM;
    check("write_count", 32'(wq_addr.size()), 32'(nw));
    for (int i = 0; i < int'(nw) && wq_addr.size() > 0; i++) begin
      check("write_addr", wq_addr.pop_front(), BASE + 32'(4 * ((exp_wr + i) % DEPTH)));
      check("write_data", wq_data.pop_front(), words[i]);
      check("write_resp", 32'(wq_resp.pop_front()), 32'(err));
    end
    wq_addr.delete();
    wq_data.delete();
    wq_resp.delete();
    if (!err) exp_wr = (exp_wr + WPM) % DEPTH;
    check("wr_ptr", 32'(WR_PTR), 32'(exp_wr));
    check("irq_pulses", 32'(irq_cnt - irq0), err ? 32'd0 : 32'd1);
    check("err_flag", 32'(ERR), 32'(err));
    if (err) begin
      @(negedge HCLK);
      ERR_CLR = 1'b1;
      @(negedge HCLK);
      ERR_CLR = 1'b0;
      check("err_clear", 32'(ERR), 32'd0);
    end
  endtask

  task automatic send_msg(input logic [7:0] a, input logic [31:0] d, input bit err,
                          input int unsigned waits);
    int          lat;
    int unsigned irq0;
    cfg_wait = waits;
    err_arm  = err;
    irq0     = irq_cnt;
    raise_req(a, d);
    wait_ack(lat);
    drop_req();
    expect_msg(a, d, err, irq0);
  endtask

  // Caller leaves the ring with fewer than WPM free slots; the request must
  // stall until RD_PTR frees exactly WPM slots, then go out two cycles later.
  task automatic blocked_msg(input logic [7:0] a, input logic [31:0] d);
    int unsigned ns0;
    int unsigned irq0;
    int          lat;
    ns0      = nonseq_cnt;
    irq0     = irq_cnt;
    cfg_wait = 0;
    err_arm  = 1'b0;
    raise_req(a, d);
    repeat (12) @(posedge HCLK);
    #1;
    check("blocked_ack", 32'(ACK_IN_FROM_LC), 32'd0);
    check("blocked_bus", 32'(nonseq_cnt - ns0), 32'd0);
    @(negedge HCLK);
    RD_PTR = PW'((exp_wr + 1 + WPM) % DEPTH);
    @(posedge HCLK);
    @(posedge HCLK); #1;
    check("release_nonseq", 32'(HTRANS), 32'h2);
    wait_ack(lat);
    drop_req();
    expect_msg(a, d, 1'b0, irq0);
  endtask

  initial begin
    int          lat;
    int unsigned irq0;
    int unsigned ns0;
    int unsigned rd;
    int unsigned free;
    bit          hit;
    logic [31:0] d;

    // Reset values
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_ack", 32'(ACK_IN_FROM_LC), 32'd0);
    check("rst_htrans", 32'(HTRANS), 32'd0);
    check("rst_haddr", HADDR, BASE);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_wr_ptr", 32'(WR_PTR), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_irq", 32'(RX_IRQ), 32'd0);
    @(negedge HCLK);
    RESET  = 1'b0;
    RD_PTR = '0;

    // First message: latency, payload, pointer, IRQ
    d        = (WPM == 2) ? 32'h1234_5678 : 32'hDEAD_BEEF;
    irq0     = irq_cnt;
    cfg_wait = 0;
    raise_req(8'hAB, d);
    wait_ack(lat);
    check("req_to_nonseq", 32'(lat), 32'd4);
    drop_req();
    expect_msg(8'hAB, d, 1'b0, irq0);

    // Wait states in both phases: values held, one transfer per word
    ns0 = nonseq_cnt;
    send_msg(8'h3C, 32'hA5A5_0F0F, 1'b0, 3);
    check("wait_nonseq_count", 32'(nonseq_cnt - ns0), 32'(WPM));
    check("wait_stability", 32'(unstable_cnt), 32'd0);

    // Error response: message dropped, ERR sticky until cleared
    send_msg(8'h11, 32'h0BAD_F00D, 1'b1, 0);

    // Ring full, then released by advancing RD_PTR
    @(negedge HCLK);
    RD_PTR = PW'((exp_wr + 1) % DEPTH);
    blocked_msg(8'h22, 32'h5555_AAAA);

    // Randomised traffic against the ring model
    for (int k = 0; k < 24; k++) begin
      rd   = $urandom_range(0, DEPTH - 1);
      free = DEPTH - 1 - ((exp_wr + DEPTH - rd) % DEPTH);
      @(negedge HCLK);
      RD_PTR = PW'(rd);
      if (free >= WPM) begin
        send_msg(8'($urandom), $urandom, ($urandom_range(0, 4) == 0), $urandom_range(0, 2));
      end else begin
        blocked_msg(8'($urandom), $urandom);
      end
    end

    // Wrap-around from the top of the ring
    while (exp_wr != DEPTH - WPM) begin
      @(negedge HCLK);
      RD_PTR = PW'(exp_wr);
      send_msg(8'($urandom), $urandom, 1'b0, 0);
    end
    @(negedge HCLK);
    RD_PTR = PW'(4);
    send_msg(8'h77, 32'h0F0F_1234, 1'b0, 0);
    check("wrap_wr_ptr", 32'(WR_PTR), 32'd0);

    // Reset during a stalled address phase abandons the transfer
    @(negedge HCLK);
    RD_PTR   = PW'(exp_wr);
    cfg_wait = 3;
    err_arm  = 1'b0;
    raise_req(8'h5A, 32'hCAFE_F00D);
    hit = 1'b0;
    for (int i = 0; i < int'(TIMEOUT) && !hit; i++) begin
      @(posedge HCLK); #1;
      if (HTRANS == 2'b10) hit = 1'b1;
    end
    check("abort_reach_addr", 32'(hit), 32'd1);
    @(negedge HCLK);
    RESET         = 1'b1;
    REQ_OUT_TO_LC = 1'b0;
    @(posedge HCLK); #1;
    check("abort_htrans", 32'(HTRANS), 32'd0);
    check("abort_wr_ptr", 32'(WR_PTR), 32'd0);
    @(negedge HCLK);
    RESET    = 1'b0;
    RD_PTR   = '0;
    exp_wr   = 0;
    cfg_wait = 0;

    // Reset while acknowledging drops ACK at once
    raise_req(8'h01, 32'h0000_0001);
    wait_ack(lat);
    @(negedge HCLK);
    RESET         = 1'b1;
    REQ_OUT_TO_LC = 1'b0;
    @(posedge HCLK); #1;
    check("abort_ack", 32'(ACK_IN_FROM_LC), 32'd0);
    @(negedge HCLK);
    RESET  = 1'b0;
    exp_wr = 0;
    wq_addr.delete();
    wq_data.delete();
    wq_resp.delete();

    // Recovery after reset
    send_msg(8'hC3, 32'h600D_CAFE, 1'b0, 1);

    check("final_stability", 32'(unstable_cnt), 32'd0);
    check("constant_outputs", 32'(const_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
